// File: rtl/fp16_div.sv
// Purpose: IEEE 754 half-precision divider, result = a / b, truncating, flush-to-zero.
// Latency: 15 edges from accept (counting the accept edge) for normal operands, 1 edge for special cases.
// Backpressure: single operation in flight; in_ready low until result handshake, result held while out_ready low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake for a (dividend) and b (divisor)
//   out_valid/out_ready result handshake
//   result              registered fp16 quotient
module fp16_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  cnt;
    logic [11:0] rem;
    logic [12:0] quo;
    logic [10:0] mb_r;
    logic [6:0]  exp_r;
    logic        sign_r;

    // ---------------- operand decode (combinational, used at accept) ----------------
    logic [4:0] a_exp, b_exp;
    logic [9:0] a_man, b_man;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic       sign_in, is_special, accept;
    logic [15:0] spec_res;

    assign a_exp = a[14:10];
    assign b_exp = b[14:10];
    assign a_man = a[9:0];
    assign b_man = b[9:0];

    // Exponent zero covers both true zero and denormals, which are flushed.
    assign a_zero = (a_exp == 5'd0);
    assign b_zero = (b_exp == 5'd0);
    assign a_inf  = (a_exp == 5'h1F) && (a_man == 10'd0);
    assign b_inf  = (b_exp == 5'h1F) && (b_man == 10'd0);
    assign a_nan  = (a_exp == 5'h1F) && (a_man != 10'd0);
    assign b_nan  = (b_exp == 5'h1F) && (b_man != 10'd0);

    assign sign_in    = a[15] ^ b[15];
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign accept     = in_valid && in_ready;

    // Special results in priority order; only meaningful when is_special.
    always_comb begin
        spec_res = {sign_in, 15'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = 16'h7E00;
        end else if (a_inf) begin
            spec_res = {sign_in, 5'h1F, 10'd0};
        end else if (b_zero) begin
            spec_res = {sign_in, 5'h1F, 10'd0};
        end else if (a_zero) begin
            spec_res = {sign_in, 15'd0};
        end else if (b_inf) begin
            spec_res = {sign_in, 15'd0};
        end
    end

    // ---------------- restoring division step ----------------
    logic        rem_ge;
    logic [11:0] rem_diff;

    assign rem_ge   = (rem >= {1'b0, mb_r});
    assign rem_diff = rem_ge ? (rem - {1'b0, mb_r}) : rem;

    // ---------------- normalisation and range check ----------------
    logic [9:0]  norm_mant;
    logic [6:0]  norm_exp;
    logic [15:0] norm_res;
    logic        norm_unused;

    // The quotient LSB only matters as a guard bit, and no rounding is done.
    assign norm_unused = quo[0];

    always_comb begin
        norm_mant = quo[11:2];
        norm_exp  = exp_r;
        if (!quo[12]) begin
            norm_mant = quo[10:1];
            norm_exp  = exp_r - 7'd1;
        end
        if ($signed(norm_exp) >= 7'sd31) begin
            norm_res = {sign_r, 5'h1F, 10'd0};
        end else if ($signed(norm_exp) <= 7'sd0) begin
            norm_res = {sign_r, 15'd0};
        end else begin
            norm_res = {sign_r, norm_exp[4:0], norm_mant};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_special ? DONE : ITER;
            ITER: if (cnt == 4'd12) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            rem    <= 12'd0;
            quo    <= 13'd0;
            mb_r   <= 11'd0;
            exp_r  <= 7'd0;
            sign_r <= 1'b0;
            result <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r <= sign_in;
                        rem    <= {2'b01, a_man};
                        mb_r   <= {1'b1, b_man};
                        exp_r  <= {2'b00, a_exp} - {2'b00, b_exp} + 7'd15;
                        quo    <= 13'd0;
                        cnt    <= 4'd0;
                        if (is_special) begin
                            result <= spec_res;
                        end
                    end
                end
                ITER: begin
                    quo <= {quo[11:0], rem_ge};
                    rem <= rem_diff << 1;
                    cnt <= cnt + 4'd1;
                end
                NORM: begin
                    result <= norm_res;
                end
                default: begin
                    // DONE: result held until the consumer takes it.
                end
            endcase
        end
    end

endmodule

// File: doc/fp16_div.md
FP16_DIV -- requirements
Module: fp16_div

Interface
REQ-001 Parameters: none; all widths are fixed by the IEEE 754 half-precision format (sign 1, exponent 5 with bias 15, mantissa 10).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair a/b is valid this cycle.
REQ-005 in_ready  output  1  block can accept an operand pair; equals (state==IDLE).
REQ-006 a  input  16  fp16 dividend.
REQ-007 b  input  16  fp16 divisor.
REQ-008 out_valid  output  1  result holds a completed quotient.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 result  output  16  fp16 quotient a/b, registered.

Function
REQ-011 Accept: a and b SHALL be captured on the edge where in_valid && in_ready; inputs are ignored in every other cycle.
REQ-012 FSM states: IDLE, ITER, NORM, DONE. Transitions: IDLE->DONE on accept of a special case; IDLE->ITER on any other accept; ITER->NORM after 13 iterations; NORM->DONE; DONE->IDLE on out_valid && out_ready.
REQ-013 out_valid SHALL equal (state==DONE); result and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-014 No overlap: in_ready is 0 from the accept edge until the cycle after the output handshake.
REQ-015 Special cases SHALL be resolved at accept, in this priority order:
- either operand NaN, 0/0 or inf/inf -> 16'h7E00;
- inf/finite -> inf;
- finite nonzero/0 -> inf;
- 0/finite nonzero -> zero;
- finite/inf -> zero.
REQ-016 Sign of every non-NaN result (including zero and inf) SHALL be a[15]^b[15].
REQ-017 Denormal inputs (exp==0, mant!=0) SHALL be flushed to zero before the special-case check. A denormal divisor therefore yields a div-by-zero inf.
REQ-018 Significands: ma={1,a[9:0]}, mb={1,b[9:0]}. Exponent e = ea - eb + 15, held as signed 7-bit.
REQ-019 ITER SHALL perform restoring division, one quotient bit per cycle, 13 cycles, quotient q[12:0] MSB first:
- remainder rem (12 bits) initialised to ma;
- each cycle: if rem>=mb then qbit=1 and rem=rem-mb, else qbit=0; then rem=rem<<1.
REQ-020 NORM:
- if q[12]==1, mant=q[11:2];
- else mant=q[10:1] and e=e-1.
Remaining bits are truncated; no rounding.
REQ-021 Range after NORM:
- e>=31 -> signed inf (exp 5'h1F, mant 0);
- e<=0 -> signed zero (flush-to-zero, no denormal output);
- otherwise result={sign, e[4:0], mant}.
REQ-022 Latency: for a normal path, out_valid rises 15 edges after the accept edge; for a special case, 1 edge after.
REQ-023 Throughput: at most one operation in flight.

Reset
REQ-024 While rst_n is low:
- state=IDLE;
- out_valid=0;
- result=16'h0000;
- iteration counter, remainder, quotient and exponent registers cleared.
REQ-025 An accept SHALL NOT occur while rst_n is low, even though in_ready reads 1.
REQ-026 Reset asserted in any state SHALL abandon the operation in progress. No result is produced for it, and the first edge after release starts in IDLE.

Verification
REQ-027 a=3C00 (1.0), b=4000 (2.0), out_ready=1 -> result=3800, out_valid 15 edges after accept, in_ready high the following cycle.
REQ-028 Quotient ranges:
- 4200/4000 -> 3E00 (q[12]=1 path);
- 3C00/4200 -> 3555 (q[12]=0 path, truncated 1/3).
REQ-029 Special cases, each with 1-edge latency:
- C000/0000 -> FC00;
- 0000/0000 -> 7E00;
- 7C00/7C00 -> 7E00;
- 7E01/3C00 -> 7E00;
- 3C00/FC00 -> 8000.
REQ-030 Range and flush:
- 7BFF/3800 -> 7C00 (overflow);
- 0400/7800 -> 0000 (underflow);
- 3C00/0001 -> 7C00 (denormal divisor flushed);
- 0001/3C00 -> 0000 (denormal dividend flushed).
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0, new in_valid ignored. Release -> one handshake, then IDLE.
REQ-032 Reset mid-operation: drop rst_n during ITER cycle 6 -> out_valid=0 and result=0000 immediately. After release, a fresh 4200/4000 completes as 3E00 with normal latency.
